// File: rtl/madd_err_accum.sv
`default_nettype none
// ============================================================================
//  Module   : madd_err_accum
//  Purpose  : Error-statistics stage for 4-bit approximate multiply-add
//             circuits. Each accepted beat carries one approximate result and
//             the exact result for the same input vector. Over a run the
//             block accumulates sample count, erroneous-sample count, sum of
//             absolute error and maximum absolute error. Final results are
//             presented behind a valid/ack handshake.
//  Ports    : clk, rst (async, active-high)
//             i_start                  clear stats and begin a run (IDLE/DONE)
//             i_in_valid/o_in_ready    beat handshake, i_in_last marks end
//             i_approx_val/i_exact_val unsigned OUT_W operands
//             o_res_valid/i_res_ack    result handshake
//             o_busy                   high while running or draining
//             o_sample_cnt, o_err_cnt, o_sum_abs_err, o_max_abs_err, o_sat
//  Revision : 1.0  initial release
// ============================================================================
module madd_err_accum #(
    parameter int OUT_W = 12,
    parameter int CNT_W = 20,
    parameter int SUM_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic             i_in_last,
    input  logic [OUT_W-1:0] i_approx_val,
    input  logic [OUT_W-1:0] i_exact_val,
    output logic             o_res_valid,
    input  logic             i_res_ack,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_sample_cnt,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [SUM_W-1:0] o_sum_abs_err,
    output logic [OUT_W-1:0] o_max_abs_err,
    output logic             o_sat
);

    // Accumulator for the sum is wide enough that one add of a full-scale
    // error can never wrap before the saturation check sees it.
    localparam int c_ACC_W = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;

    // Stage 0: captured beat
    logic               r_v0;
    logic               r_last0;
    logic [OUT_W-1:0]   r_a0;
    logic [OUT_W-1:0]   r_e0;

    // Stage 1: absolute error
    logic               r_v1;
    logic               r_last1;
    logic [OUT_W-1:0]   r_d1;
    logic               r_ne1;

    // Statistics
    logic [CNT_W-1:0]   r_sample_cnt;
    logic [CNT_W-1:0]   r_err_cnt;
    logic [SUM_W-1:0]   r_sum_abs_err;
    logic [OUT_W-1:0]   r_max_abs_err;
    logic               r_sat;

    logic               w_accept;
    logic               w_clear;
    logic signed [OUT_W:0] w_diff;
    logic [OUT_W-1:0]   w_abs;
    logic [CNT_W:0]     w_samp_full;
    logic [CNT_W:0]     w_err_full;
    logic [c_ACC_W-1:0] w_sum_full;
    logic               w_samp_ovf;
    logic               w_err_ovf;
    logic               w_sum_ovf;
    logic [CNT_W-1:0]   w_samp_nxt;
    logic [CNT_W-1:0]   w_err_nxt;
    logic [SUM_W-1:0]   w_sum_nxt;

    assign w_accept = i_in_valid && (r_state == S_RUN);
    assign w_clear  = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Signed difference in OUT_W+1 bits; the magnitude always fits OUT_W.
    assign w_diff = $signed({1'b0, r_a0}) - $signed({1'b0, r_e0});
    assign w_abs  = w_diff[OUT_W] ? OUT_W'(-w_diff) : OUT_W'(w_diff);

    // Saturating updates: an extra carry bit flags an add past all-ones.
    assign w_samp_full = {1'b0, r_sample_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign w_err_full  = {1'b0, r_err_cnt} + {{CNT_W{1'b0}}, r_ne1};
    assign w_sum_full  = c_ACC_W'(r_sum_abs_err) + c_ACC_W'(r_d1);

    assign w_samp_ovf = w_samp_full[CNT_W];
    assign w_err_ovf  = w_err_full[CNT_W];
    assign w_sum_ovf  = |(w_sum_full >> SUM_W);

    assign w_samp_nxt = w_samp_ovf ? {CNT_W{1'b1}} : w_samp_full[CNT_W-1:0];
    assign w_err_nxt  = w_err_ovf  ? {CNT_W{1'b1}} : w_err_full[CNT_W-1:0];
    assign w_sum_nxt  = w_sum_ovf  ? {SUM_W{1'b1}} : w_sum_full[SUM_W-1:0];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_accept && i_in_last) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // The last beat reaches the accumulators on this edge.
                    if (r_v1 && r_last1) r_state <= S_DONE;
                end
                S_DONE: begin
                    if (i_start)        r_state <= S_RUN;
                    else if (i_res_ack) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Two-stage datapath pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v0    <= 1'b0;
            r_last0 <= 1'b0;
            r_a0    <= '0;
            r_e0    <= '0;
            r_v1    <= 1'b0;
            r_last1 <= 1'b0;
            r_d1    <= '0;
            r_ne1   <= 1'b0;
        end else begin
            r_v0    <= w_accept;
            r_last0 <= w_accept && i_in_last;
            if (w_accept) begin
                r_a0 <= i_approx_val;
                r_e0 <= i_exact_val;
            end
            r_v1    <= r_v0;
            r_last1 <= r_v0 && r_last0;
            if (r_v0) begin
                r_d1  <= w_abs;
                r_ne1 <= (w_abs != '0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Accumulators. A clear cannot collide with a pipeline update because
    // start is only honoured once the pipeline has drained.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample_cnt  <= '0;
            r_err_cnt     <= '0;
            r_sum_abs_err <= '0;
            r_max_abs_err <= '0;
            r_sat         <= 1'b0;
        end else if (w_clear) begin
            r_sample_cnt  <= '0;
            r_err_cnt     <= '0;
            r_sum_abs_err <= '0;
            r_max_abs_err <= '0;
            r_sat         <= 1'b0;
        end else if (r_v1) begin
            r_sample_cnt  <= w_samp_nxt;
            r_err_cnt     <= w_err_nxt;
            r_sum_abs_err <= w_sum_nxt;
            if (r_d1 > r_max_abs_err) r_max_abs_err <= r_d1;
            if (w_samp_ovf || w_err_ovf || w_sum_ovf) r_sat <= 1'b1;
        end
    end

    assign o_in_ready    = (r_state == S_RUN);
    assign o_busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign o_res_valid   = (r_state == S_DONE);
    assign o_sample_cnt  = r_sample_cnt;
    assign o_err_cnt     = r_err_cnt;
    assign o_sum_abs_err = r_sum_abs_err;
    assign o_max_abs_err = r_max_abs_err;
    assign o_sat         = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_madd_err_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_madd_err_accum
//  Purpose  : Self-checking bench for madd_err_accum. Two instances share all
//             inputs: one with default widths, one with an 8-bit error sum so
//             that saturation is reachable. Expected statistics come from the
//             list of beats sent in each run.
//  Revision : 1.0  initial release
// ============================================================================
module tb_madd_err_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start, i_in_valid, i_in_last, i_res_ack;
    logic [11:0] i_approx_val, i_exact_val;

    logic        o_in_ready, o_res_valid, o_busy, o_sat;
    logic [19:0] o_sample_cnt, o_err_cnt;
    logic [31:0] o_sum_abs_err;
    logic [11:0] o_max_abs_err;

    logic        o8_in_ready, o8_res_valid, o8_busy, o8_sat;
    logic [19:0] o8_sample_cnt, o8_err_cnt;
    logic [7:0]  o8_sum_abs_err;
    logic [11:0] o8_max_abs_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [11:0] qa[$];
    logic [11:0] qe[$];

    always #5 clk = ~clk;

    madd_err_accum dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_in_valid(i_in_valid),
        .o_in_ready(o_in_ready), .i_in_last(i_in_last),
        .i_approx_val(i_approx_val), .i_exact_val(i_exact_val),
        .o_res_valid(o_res_valid), .i_res_ack(i_res_ack), .o_busy(o_busy),
        .o_sample_cnt(o_sample_cnt), .o_err_cnt(o_err_cnt),
        .o_sum_abs_err(o_sum_abs_err), .o_max_abs_err(o_max_abs_err),
        .o_sat(o_sat)
    );

    madd_err_accum #(.OUT_W(12), .CNT_W(20), .SUM_W(8)) dut8 (
        .clk(clk), .rst(rst), .i_start(i_start), .i_in_valid(i_in_valid),
        .o_in_ready(o8_in_ready), .i_in_last(i_in_last),
        .i_approx_val(i_approx_val), .i_exact_val(i_exact_val),
        .o_res_valid(o8_res_valid), .i_res_ack(i_res_ack), .o_busy(o8_busy),
        .o_sample_cnt(o8_sample_cnt), .o_err_cnt(o8_err_cnt),
        .o_sum_abs_err(o8_sum_abs_err), .o_max_abs_err(o8_max_abs_err),
        .o_sat(o8_sat)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Fill the beat queues. mode 0: mixed, 1: exact, 2: |d|=1, 3: |d|=100
    task automatic gen(input int n, input int mode);
        int a, e;
        qa.delete();
        qe.delete();
        for (int i = 0; i < n; i++) begin
            case (mode)
                1: begin a = $urandom_range(4095); e = a; end
                2: begin
                    a = $urandom_range(4094);
                    e = a + 1;
                    if ($urandom_range(1) == 1) begin e = a; a = a + 1; end
                end
                3: begin
                    a = $urandom_range(3995);
                    e = a + 100;
                    if ($urandom_range(1) == 1) begin e = a; a = a + 100; end
                end
                default: begin
                    case ($urandom_range(3))
                        0: begin a = $urandom_range(4095); e = a; end
                        1: begin a = $urandom_range(4095); e = $urandom_range(4095); end
                        2: begin
                            e = $urandom_range(4095);
                            a = e + $urandom_range(6) - 3;
                            if (a < 0) a = 0;
                            if (a > 4095) a = 4095;
                        end
                        default: begin
                            a = ($urandom_range(1) == 1) ? 4095 : 0;
                            e = ($urandom_range(1) == 1) ? 4095 : 0;
                        end
                    endcase
                end
            endcase
            qa.push_back(12'(a));
            qe.push_back(12'(e));
        end
    endtask

    // Reference statistics straight from the beat list.
    task automatic check_stats(input string tag);
        longint s = 0;
        longint mx = 0;
        longint ne = 0;
        longint d;
        for (int i = 0; i < qa.size(); i++) begin
            d = longint'(qa[i]) - longint'(qe[i]);
            if (d < 0) d = -d;
            s += d;
            if (d != 0) ne++;
            if (d > mx) mx = d;
        end
        chk({tag, ".res_valid"}, o_res_valid, 1);
        chk({tag, ".sample_cnt"}, o_sample_cnt, qa.size());
        chk({tag, ".err_cnt"}, o_err_cnt, ne);
        chk({tag, ".sum"}, o_sum_abs_err, (s > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : s);
        chk({tag, ".max"}, o_max_abs_err, mx);
        chk({tag, ".sat"}, o_sat, (s > 64'hFFFF_FFFF) ? 1 : 0);
        chk({tag, ".s8_sample_cnt"}, o8_sample_cnt, qa.size());
        chk({tag, ".s8_sum"}, o8_sum_abs_err, (s > 255) ? 255 : s);
        chk({tag, ".s8_sat"}, o8_sat, (s > 255) ? 1 : 0);
    endtask

    // Send the queued beats as one run. Caller is 1 ns after a rising edge.
    task automatic send_run(input bit do_start, input int gap_pct, input bit poke_start);
        int stalls = 0;
        int lat = 0;
        int waited;
        if (do_start) begin
            i_start = 1'b1;
            @(posedge clk); #1;
            i_start = 1'b0;
        end
        for (int i = 0; i < qa.size(); i++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                i_in_valid = 1'b0;
                i_in_last  = 1'($urandom_range(1));
                i_start    = poke_start ? 1'($urandom_range(1)) : 1'b0;
                @(posedge clk); #1;
            end
            i_in_valid   = 1'b1;
            i_approx_val = qa[i];
            i_exact_val  = qe[i];
            i_in_last    = (i == qa.size() - 1);
            i_start      = poke_start ? 1'($urandom_range(1)) : 1'b0;
            waited = 0;
            while (!o_in_ready && waited < 20) begin
                stalls++;
                @(posedge clk); #1;
                waited++;
            end
            @(posedge clk); #1;
        end
        i_in_valid = 1'b0;
        i_in_last  = 1'b0;
        i_start    = poke_start;
        chk("drain_busy", o_busy, 1);
        while (!o_res_valid && lat < 10) begin
            @(posedge clk); #1;
            i_start = 1'b0;
            lat++;
        end
        i_start = 1'b0;
        chk("res_latency", lat, 2);
        chk("stalls", stalls, 0);
    endtask

    task automatic finish_run(input int hold);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
            end
            check_stats("hold");
        end
        i_res_ack = 1'b1;
        @(posedge clk); #1;
        i_res_ack = 1'b0;
        chk("ack.res_valid", o_res_valid, 0);
        chk("ack.busy", o_busy, 0);
        chk("ack.in_ready", o_in_ready, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        i_start = 0; i_in_valid = 0; i_in_last = 0; i_res_ack = 0;
        i_approx_val = 0; i_exact_val = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.in_ready", o_in_ready, 0);
        chk("rst.res_valid", o_res_valid, 0);
        chk("rst.busy", o_busy, 0);
        chk("rst.sample_cnt", o_sample_cnt, 0);
        chk("rst.sum", o_sum_abs_err, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset mid-run with three beats in flight.
        gen(3, 0);
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_in_valid = 1'b1; i_in_last = 1'b0;
            i_approx_val = 12'd4000; i_exact_val = 12'd1;
            @(posedge clk); #1;
        end
        chk("pre_rst.sample_cnt", o_sample_cnt, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst.in_ready", o_in_ready, 0);
        chk("mid_rst.busy", o_busy, 0);
        chk("mid_rst.sample_cnt", o_sample_cnt, 0);
        chk("mid_rst.err_cnt", o_err_cnt, 0);
        chk("mid_rst.sum", o_sum_abs_err, 0);
        chk("mid_rst.max", o_max_abs_err, 0);
        chk("mid_rst.sat", o8_sat, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst.in_ready", o_in_ready, 0);
        chk("post_rst.sample_cnt", o_sample_cnt, 0);
        i_in_valid = 1'b0;

        // Four exact beats.
        qa = '{12'd100, 12'd100, 12'd100, 12'd100};
        qe = '{12'd100, 12'd100, 12'd100, 12'd100};
        send_run(1, 0, 0);
        check_stats("exact4");
        finish_run(0);

        // Directed errors, then a held result and start+ack together.
        qa = '{12'd10, 12'd7, 12'd4095, 12'd5};
        qe = '{12'd7, 12'd10, 12'd0, 12'd5};
        send_run(1, 0, 0);
        check_stats("directed");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        check_stats("held10");
        i_start = 1'b1; i_res_ack = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0; i_res_ack = 1'b0;
        chk("restart.busy", o_busy, 1);
        chk("restart.res_valid", o_res_valid, 0);
        chk("restart.sample_cnt", o_sample_cnt, 0);
        chk("restart.max", o_max_abs_err, 0);
        chk("restart.sat8", o8_sat, 0);
        gen(6, 0);
        send_run(0, 0, 0);
        check_stats("after_restart");
        finish_run(1);

        // Back-to-back streaming of |d|=1 beats.
        gen(5000, 2);
        send_run(1, 0, 0);
        check_stats("stream");
        finish_run(0);

        // Saturation of the narrow sum and its clear on the next start.
        gen(3, 3);
        send_run(1, 0, 0);
        check_stats("sat3");
        finish_run(0);
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("sat_clear.sat8", o8_sat, 0);
        chk("sat_clear.sum8", o8_sum_abs_err, 0);
        gen(1, 0);
        send_run(0, 0, 0);
        check_stats("one_beat");
        finish_run(0);

        // Randomized runs with gaps, ignored starts and varied holds.
        for (int r = 0; r < 25; r++) begin
            gen((r % 5 == 0) ? 1 : int'($urandom_range(2, 30)), 0);
            send_run(1, 20, 1);
            check_stats($sformatf("rand%0d", r));
            finish_run($urandom_range(3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
